// File: rtl/coeff_decomposer_mlane_if.sv
// rtl/coeff_decomposer_mlane_if.sv - beat-level handshake bundle for the multi-lane decomposer
interface coeff_decomposer_mlane_if #(
    parameter int LANES    = 4,
    parameter int COEFF_W  = 24,
    parameter int OUTPUT_W = 6
);
    logic [2:0]                sec_lvl;
    logic                      mode;
    logic                      valid_i;
    logic                      ready_i;
    logic [LANES*COEFF_W-1:0]  di;
    logic [LANES-1:0]          hint_i;
    logic [LANES*OUTPUT_W-1:0] doa;
    logic [LANES*COEFF_W-1:0]  dob;
    logic                      valid_o;
    logic                      ready_o;

    modport master (
        output sec_lvl, mode, valid_i, di, hint_i, ready_o,
        input  ready_i, doa, dob, valid_o
    );

    modport slave (
        input  sec_lvl, mode, valid_i, di, hint_i, ready_o,
        output ready_i, doa, dob, valid_o
    );
endinterface

// File: rtl/coeff_decomposer_mlane.sv
// rtl/coeff_decomposer_mlane.sv - three-stage multi-lane Dilithium Decompose/UseHint pipeline
module coeff_decomposer_mlane #(
    parameter int LANES    = 4,
    parameter int COEFF_W  = 24,
    parameter int OUTPUT_W = 6
) (
    input  logic clk,
    input  logic rst,
    coeff_decomposer_mlane_if.slave bus
);
    localparam logic [23:0] Q        = 24'd8380417;
    localparam logic [23:0] TWO_Q    = 24'd16760834;
    localparam int          GAMMA_88 = 95232;
    localparam int          GAMMA_32 = 261888;

    // Any 24-bit input is below 3q, so two conditional subtracts suffice.
    function automatic logic [22:0] reduce_q(input logic [23:0] x);
        logic [23:0] t;
        t = (x >= TWO_Q) ? x - TWO_Q : x;
        t = (t >= Q) ? t - Q : t;
        return 23'(t);
    endfunction

    // Compare tree against k*alpha; r < q guarantees the quotient never exceeds 44.
    // Returns {centred quotient, centred remainder}.
    function automatic logic [29:0] split(input logic [22:0] r, input logic g88);
        int         gamma;
        int         alpha;
        int         rem;
        logic [5:0] quo;
        gamma = g88 ? GAMMA_88 : GAMMA_32;
        alpha = 2 * gamma;
        quo   = '0;
        for (int k = 1; k <= 44; k++) begin
            if (int'(r) >= k * alpha) quo = 6'(k);
        end
        rem = int'(r) - int'(quo) * alpha;
        if (rem > gamma) begin
            rem = rem - alpha;
            quo = quo + 6'd1;
        end
        return {quo, 24'(rem)};
    endfunction

    // A centred quotient equal to m means r - r0 = q-1, which folds back to r1 = 0.
    function automatic logic [29:0] finish_lane(input logic [5:0] r1c, input logic [23:0] r0c,
                                                input logic g88, input logic use_hint);
        logic [5:0]         top;
        logic [5:0]         r1;
        logic signed [23:0] r0;
        top = g88 ? 6'd43 : 6'd15;
        r1  = r1c;
        r0  = r0c;
        if (r1c == top + 6'd1) begin
            r1 = '0;
            r0 = r0 - 24'sd1;
        end
        if (use_hint) begin
            if (r0 > 24'sd0) r1 = (r1 == top) ? 6'd0 : r1 + 6'd1;
            else             r1 = (r1 == 6'd0) ? top : r1 - 6'd1;
        end
        return {r1, r0};
    endfunction

    logic                      adv;
    logic                      s1_valid;
    logic                      s2_valid;
    logic                      s1_g88;
    logic                      s2_g88;
    logic                      s1_mode;
    logic                      s2_mode;
    logic [LANES-1:0]          s1_hint;
    logic [LANES-1:0]          s2_hint;
    logic [22:0]               s1_r   [LANES];
    logic [5:0]                s2_r1  [LANES];
    logic [23:0]               s2_r0  [LANES];
    logic [22:0]               s1_r_n [LANES];
    logic [29:0]               s2_n   [LANES];
    logic [29:0]               s3_n   [LANES];
    logic [LANES*OUTPUT_W-1:0] doa_n;
    logic [LANES*COEFF_W-1:0]  dob_n;

    assign adv         = ~bus.valid_o | bus.ready_o;
    assign bus.ready_i = adv;

    always_comb begin
        doa_n = '0;
        dob_n = '0;
        for (int k = 0; k < LANES; k++) begin
            s1_r_n[k] = reduce_q(bus.di[k*COEFF_W +: 24]);
            s2_n[k]   = split(s1_r[k], s1_g88);
            s3_n[k]   = finish_lane(s2_r1[k], s2_r0[k], s2_g88, s2_mode & s2_hint[k]);
            doa_n[k*OUTPUT_W +: OUTPUT_W] = OUTPUT_W'(s3_n[k][29:24]);
            dob_n[k*COEFF_W +: COEFF_W]   = COEFF_W'(s3_n[k][23:0]);
        end
    end

    // The whole pipeline freezes together when the output beat is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            bus.valid_o <= 1'b0;
            bus.doa     <= '0;
            bus.dob     <= '0;
        end else if (adv) begin
            s1_valid    <= bus.valid_i;
            s1_g88      <= (bus.sec_lvl == 3'b010);
            s1_mode     <= bus.mode;
            s1_hint     <= bus.hint_i;
            s2_valid    <= s1_valid;
            s2_g88      <= s1_g88;
            s2_mode     <= s1_mode;
            s2_hint     <= s1_hint;
            bus.valid_o <= s2_valid;
            bus.doa     <= doa_n;
            bus.dob     <= dob_n;
            for (int k = 0; k < LANES; k++) begin
                s1_r[k]  <= s1_r_n[k];
                s2_r1[k] <= s2_n[k][29:24];
                s2_r0[k] <= s2_n[k][23:0];
            end
        end
    end
endmodule

// File: tb/tb_coeff_decomposer_mlane.sv
// tb/tb_coeff_decomposer_mlane.sv - randomized scoreboard bench for coeff_decomposer_mlane
module tb_coeff_decomposer_mlane;
    localparam int L  = 4;
    localparam int CW = 24;
    localparam int OW = 6;
    localparam int Q  = 8380417;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coeff_decomposer_mlane_if #(.LANES(L), .COEFF_W(CW), .OUTPUT_W(OW)) bus ();
    coeff_decomposer_mlane #(.LANES(L), .COEFF_W(CW), .OUTPUT_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [L*OW-1:0] a;
        logic [L*CW-1:0] b;
        int              c;
    } exp_t;

    exp_t            exp_q[$];
    int              n_cmp      = 0;
    int              n_bad      = 0;
    int              cyc        = 0;
    bit              strict_lat = 1'b0;
    int              rdy_mode   = 0;
    logic            held       = 1'b0;
    logic [L*OW-1:0] held_a;
    logic [L*CW-1:0] held_b;
    int              edge_v[12] = '{0, 1, 8380416, 8380417, 16760833, 16760834, 16777215,
                                    95232, 95233, 261888, 261889, 8189952};

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp_v);
        end
    endtask

    // Reference straight from the definition: centred mod, then the q-1 special case, then the hint.
    function automatic logic [L*OW+L*CW-1:0] model(input logic [L*CW-1:0] di, input logic [2:0] sec,
                                                   input logic md, input logic [L-1:0] h);
        int g, a, m, r, r0, r1;
        logic [L*OW-1:0] oa;
        logic [L*CW-1:0] ob;
        g = (sec == 3'b010) ? (Q - 1) / 88 : (Q - 1) / 32;
        a = 2 * g;
        m = (Q - 1) / a;
        for (int k = 0; k < L; k++) begin
            r  = int'(di[k*CW +: CW]) % Q;
            r0 = r % a;
            if (r0 > g) r0 = r0 - a;
            if (r - r0 == Q - 1) begin
                r1 = 0;
                r0 = r0 - 1;
            end else begin
                r1 = (r - r0) / a;
            end
            if (md && h[k]) r1 = (r0 > 0) ? (r1 + 1) % m : (r1 + m - 1) % m;
            oa[k*OW +: OW] = OW'(r1);
            ob[k*CW +: CW] = CW'(r0);
        end
        return {oa, ob};
    endfunction

    function automatic logic [L*CW-1:0] p24(input int a3, input int a2, input int a1, input int a0);
        return {24'(a3), 24'(a2), 24'(a1), 24'(a0)};
    endfunction

    function automatic logic [L*OW-1:0] p6(input int a3, input int a2, input int a1, input int a0);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    function automatic logic [23:0] rand_di();
        if ($urandom_range(0, 3) == 0) return 24'(edge_v[$urandom_range(0, 11)]);
        return 24'($urandom());
    endfunction

    function automatic logic [2:0] rand_sec();
        if ($urandom_range(0, 1) == 1) return 3'b010;
        return 3'($urandom_range(0, 7));
    endfunction

    always @(posedge clk) cyc++;

    initial begin
        bus.ready_o = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.ready_o = 1'b0;
                1:       bus.ready_o = 1'b1;
                default: bus.ready_o = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        exp_t            e;
        logic [119:0]    m;
        if (rst) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            check("ready_i", 128'(bus.ready_i), 128'(!(bus.valid_o && !bus.ready_o)));
            if (held) begin
                check("stall_valid", 128'(bus.valid_o), 128'(1));
                check("stall_doa", 128'(bus.doa), 128'(held_a));
                check("stall_dob", 128'(bus.dob), 128'(held_b));
            end
            if (bus.valid_o && bus.ready_o) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: doa %0h dob %0h with no beat outstanding",
                             bus.doa, bus.dob);
                end else begin
                    e = exp_q.pop_front();
                    check("doa", 128'(bus.doa), 128'(e.a));
                    check("dob", 128'(bus.dob), 128'(e.b));
                    if (strict_lat) check("latency", 128'(cyc - e.c), 128'(3));
                end
            end else if (bus.valid_o) begin
                held   = 1'b1;
                held_a = bus.doa;
                held_b = bus.dob;
            end else begin
                held = 1'b0;
            end
            if (bus.valid_i && bus.ready_i) begin
                m   = model(bus.di, bus.sec_lvl, bus.mode, bus.hint_i);
                e.a = m[119:96];
                e.b = m[95:0];
                e.c = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [L*CW-1:0] d, input logic [2:0] s, input logic md,
                        input logic [L-1:0] h);
        int   n;
        logic ok;
        n           = 0;
        ok          = 1'b0;
        bus.valid_i = 1'b1;
        bus.di      = d;
        bus.sec_lvl = s;
        bus.mode    = md;
        bus.hint_i  = h;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.ready_i;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: ready_i stayed 0 for %0d cycles, required 1", n);
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic send_rand(input logic [2:0] s, input logic md);
        send({rand_di(), rand_di(), rand_di(), rand_di()}, s, md, 4'($urandom_range(0, 15)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(4);
        check("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    logic [119:0] pm;
    logic [2:0]   mix_sec[4] = '{3'b010, 3'b000, 3'b111, 3'b010};

    initial begin
        bus.valid_i = 1'b0;
        bus.di      = '0;
        bus.sec_lvl = '0;
        bus.mode    = 1'b0;
        bus.hint_i  = '0;

        pm = model(p24(2312250, 5000020, 8380416, 8200000), 3'b000, 1'b0, 4'b0000);
        check("pin1_r1", 128'(pm[119:96]), 128'(p6(4, 10, 0, 0)));
        check("pin1_r0", 128'(pm[95:0]), 128'(p24(217146, -237740, -1, -180417)));
        pm = model(p24(2312250, 5000020, 8380416, 8200000), 3'b111, 1'b0, 4'b0000);
        check("pin1b_r1", 128'(pm[119:96]), 128'(p6(4, 10, 0, 0)));
        pm = model(p24(8194721, 9000000, 16777215, 95233), 3'b010, 1'b0, 4'b0000);
        check("pin2_r1", 128'(pm[119:96]), 128'(p6(43, 3, 0, 1)));
        check("pin2_r0", 128'(pm[95:0]), 128'(p24(4769, 48191, 16381, -95231)));
        pm = model(p24(8194721, 95233, 95232, 16777215), 3'b010, 1'b1, 4'b1111);
        check("pin3_r1", 128'(pm[119:96]), 128'(p6(0, 0, 1, 1)));
        check("pin3_r0", 128'(pm[95:0]), 128'(p24(4769, -95231, 95232, 16381)));
        pm = model(p24(8194721, 95233, 95232, 16777215), 3'b010, 1'b1, 4'b0000);
        check("pin4_r1", 128'(pm[119:96]), 128'(p6(43, 1, 0, 0)));
        pm = model(p24(8200000, 2312250, 5000020, 8380416), 3'b000, 1'b1, 4'b1111);
        check("pin5_r1", 128'(pm[119:96]), 128'(p6(15, 5, 9, 15)));
        pm = model(p24(8200000, 2312250, 5000020, 8380416), 3'b000, 1'b1, 4'b0000);
        check("pin6_r1", 128'(pm[119:96]), 128'(p6(0, 4, 10, 0)));

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid_o", 128'(bus.valid_o), 128'(0));
        check("rst_doa", 128'(bus.doa), 128'(0));
        check("rst_dob", 128'(bus.dob), 128'(0));
        check("rst_ready_i", 128'(bus.ready_i), 128'(1));

        rdy_mode   = 1;
        strict_lat = 1'b1;
        idle(1);
        send(p24(2312250, 5000020, 8380416, 8200000), 3'b000, 1'b0, 4'b0000);
        send(p24(8194721, 9000000, 16777215, 95233), 3'b010, 1'b0, 4'b0000);
        send(p24(8194721, 95233, 95232, 16777215), 3'b010, 1'b1, 4'b1111);
        send(p24(8194721, 95233, 95232, 16777215), 3'b010, 1'b1, 4'b0000);
        send(p24(8200000, 2312250, 5000020, 8380416), 3'b000, 1'b1, 4'b1111);
        send(p24(8200000, 2312250, 5000020, 8380416), 3'b000, 1'b1, 4'b0000);
        drain();

        for (int i = 0; i < 12; i++) send_rand(mix_sec[i % 4], 1'(i % 3 != 0));
        drain();

        strict_lat = 1'b0;
        rdy_mode   = 2;
        for (int i = 0; i < 20; i++) begin
            send_rand(rand_sec(), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        drain();

        rdy_mode   = 1;
        idle(1);
        strict_lat = 1'b1;
        send(p24(1, 2, 3, 4), 3'b010, 1'b0, 4'b0000);
        send(p24(5, 6, 7, 8), 3'b000, 1'b1, 4'b1111);
        send(p24(9, 10, 11, 12), 3'b010, 1'b1, 4'b1010);
        rdy_mode = 0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_valid_o", 128'(bus.valid_o), 128'(0));
        check("midrst_doa", 128'(bus.doa), 128'(0));
        check("midrst_dob", 128'(bus.dob), 128'(0));
        rdy_mode = 1;
        send(p24(8380416, 95232, 16777215, 4769), 3'b010, 1'b1, 4'b0110);
        drain();

        for (int i = 0; i < 40; i++) send_rand(rand_sec(), 1'($urandom_range(0, 1)));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
